act_pipe: RTL
=============

ACT_PIPE -- requirements
Module: act_pipe

Interface
REQ-001 The block SHALL have parameter PREC, default 16, lane element width in bits, two's-complement signed fixed-point.
REQ-002 The block SHALL have parameter LANES, default 4, number of parallel elements per transfer (>=1).
REQ-003 The block SHALL have parameter CNTW, default 16, width of the clip statistics counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input vector present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  LANES*PREC  lane i at bits [i*PREC +: PREC].
REQ-009 in_mode  input  2  0=pass, 1=ReLU, 2=leaky ReLU, 3=clipped ReLU; sampled with in_data.
REQ-010 leak_shift  input  $clog2(PREC)  leaky right-shift amount; sampled with in_data.
REQ-011 clip_max  input  PREC  signed clip ceiling; sampled with in_data.
REQ-012 out_valid  output  1  output vector present.
REQ-013 out_ready  input  1  downstream accepts output.
REQ-014 out_data  output  LANES*PREC  activated vector, same lane packing as in_data.
REQ-015 out_clip  output  LANES  per-lane flag: lane saturated to clip ceiling in mode 3.
REQ-016 clip_cnt  output  CNTW  running count of clipped lanes.
REQ-017 cnt_clr  input  1  synchronous clear of clip_cnt.

Function
REQ-018 Transfer occurs on a port when valid and ready are both 1 at a rising edge.
REQ-019 Two register stages: S1 captures in_data/in_mode/leak_shift/clip_max; S2 holds computed out_data/out_clip; out_valid = S2 valid.
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 vector/cycle.
REQ-021 S2 SHALL load when S2 empty or out_ready=1; S1 SHALL load when S1 empty or S1 advances into S2; in_ready = S1 empty or S1 advancing.
REQ-022 While out_valid=1 and out_ready=0, out_data/out_clip SHALL hold stable; no vector lost or duplicated.
REQ-023 Mode 0: y = x.
REQ-024 Mode 1: y = 0 if x<0, else x.
REQ-025 Mode 2: y = x >>> leak_shift (arithmetic, floor rounding) if x<0, else x; leak_shift=0 gives y=x.
REQ-026 Mode 3: cap = max(clip_max, 0); y = 0 if x<0, cap if x>cap, else x; out_clip[i]=1 only when x>cap.
REQ-027 out_clip SHALL be 0 for all lanes in modes 0-2.
REQ-028 Per-lane parameters (mode, shift, cap) SHALL apply per vector; changing them while a vector is in flight SHALL not affect it.
REQ-029 clip_cnt SHALL add popcount(out_clip) on each output transfer, saturating at 2^CNTW-1.
REQ-030 cnt_clr=1 SHALL set clip_cnt to 0 on that edge, taking priority over a simultaneous increment.
REQ-031 Output comparisons and shifts SHALL be full PREC-bit signed; no output overflow possible in any mode.

Reset
REQ-032 Reset asserted SHALL immediately clear S1/S2 valid, out_valid=0, out_data=0, out_clip=0, clip_cnt=0, regardless of clock.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deassertion; in-flight vectors at reset are discarded.

Verification (PREC=8, LANES=4)
REQ-034 Mode 1, in_data lanes {-5,0,7,-128}, out_ready=1 -> out lanes {0,0,7,0} valid exactly 2 cycles later.
REQ-035 Mode 2, leak_shift=2, lanes {-8,-1,-128,100} -> {-2,-1,-32,100}.
REQ-036 Mode 3, clip_max=6, lanes {10,6,-3,127} -> {6,6,0,6}, out_clip=4'b1001, clip_cnt increments by 2; clip_max=-4 with lane 3 -> 0, clip flagged.
REQ-037 Back-to-back 8 vectors with out_ready toggled randomly -> outputs in order, none lost/duplicated, data stable while stalled, in_ready=0 only when both stages full and out_ready=0.
REQ-038 Reset asserted mid-stream with 2 vectors in flight -> out_valid drops immediately, clip_cnt=0, next accepted vector emerges at latency 2.
REQ-039 CNTW=4 with clip_cnt=14, vector with 4 clipped lanes -> clip_cnt=15 (saturated); cnt_clr with simultaneous clipped transfer -> 0.

Source files
------------

// File: rtl/act_pipe.sv
// act_pipe -- two-stage, ready/valid activation pipeline.
//
// Each transfer carries LANES signed fixed-point elements of PREC bits. A
// per-vector activation is applied to every lane:
//   mode 0 pass, mode 1 ReLU, mode 2 leaky ReLU (arithmetic right shift of
//   negatives), mode 3 clipped ReLU (ceiling = max(clip_max, 0)).
// Stage S1 registers the raw vector together with its mode/shift/ceiling;
// stage S2 registers the activated result. Lanes that hit the ceiling in
// mode 3 are flagged in out_clip and accumulated into a saturating counter.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_data               LANES*PREC, lane i at [i*PREC +: PREC]
//   in_mode, leak_shift,
//   clip_max              per-vector controls, sampled with in_data
//   out_valid/out_ready   output handshake
//   out_data              activated vector, same packing as in_data
//   out_clip              per-lane "saturated to ceiling" flag
//   clip_cnt, cnt_clr     running clipped-lane count, synchronous clear
module act_pipe #(
  parameter int PREC  = 16,
  parameter int LANES = 4,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*PREC-1:0]      in_data,
  input  logic [1:0]                 in_mode,
  input  logic [$clog2(PREC)-1:0]    leak_shift,
  input  logic [PREC-1:0]            clip_max,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*PREC-1:0]      out_data,
  output logic [LANES-1:0]           out_clip,
  output logic [CNTW-1:0]            clip_cnt,
  input  logic                       cnt_clr
);

  localparam int SHW  = $clog2(PREC);
  localparam int PCW  = $clog2(LANES + 1);
  // Sum of counter and popcount needs one bit beyond the wider operand.
  localparam int SUMW = ((CNTW > PCW) ? CNTW : PCW) + 1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_PASS  = 2'd0;
  localparam logic [1:0] MODE_RELU  = 2'd1;
  localparam logic [1:0] MODE_LEAKY = 2'd2;
  localparam logic [1:0] MODE_CLIP  = 2'd3;

  // Stage S1: raw vector plus the controls that travel with it.
  logic                    s1_valid_q, s1_valid_d;
  logic [LANES*PREC-1:0]   s1_data_q,  s1_data_d;
  logic [1:0]              s1_mode_q,  s1_mode_d;
  logic [SHW-1:0]          s1_shift_q, s1_shift_d;
  logic [PREC-1:0]         s1_cmax_q,  s1_cmax_d;

  // Stage S2: activated result.
  logic                    s2_valid_q, s2_valid_d;
  logic [LANES*PREC-1:0]   s2_data_q,  s2_data_d;
  logic [LANES-1:0]        s2_clip_q,  s2_clip_d;

  logic [CNTW-1:0]         cnt_q, cnt_d;

  logic                    s2_load;
  logic                    in_fire;
  logic                    out_fire;
  logic [LANES*PREC-1:0]   act_data;
  logic [LANES-1:0]        act_clip;
  logic [PCW-1:0]          clip_pop;
  logic [SUMW-1:0]         cnt_sum;

  // S2 can take a new vector when it is empty or its current one leaves.
  // S1 may then refill in the same cycle it hands its vector on.
  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  // Negative clip_max collapses the ceiling to zero, shared by all lanes.
  logic signed [PREC-1:0] cap;
  assign cap = s1_cmax_q[PREC-1] ? '0 : $signed(s1_cmax_q);

  // Per-lane activation from the S1 registers. Every result lies inside
  // [min(x,0), max(x,0)], so nothing can overflow PREC bits.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [PREC-1:0] x;
      logic signed [PREC-1:0] y;
      logic                   clp;

      assign x = $signed(s1_data_q[gi*PREC +: PREC]);

      always_comb begin
        y   = x;
        clp = 1'b0;
        case (s1_mode_q)
          MODE_RELU: begin
            if (x < 0) y = '0;
          end
          MODE_LEAKY: begin
            if (x < 0) y = x >>> s1_shift_q;
          end
          MODE_CLIP: begin
            if (x < 0) begin
              y = '0;
            end else if (x > cap) begin
              y   = cap;
              clp = 1'b1;
            end
          end
          default: y = x;
        endcase
      end

      assign act_data[gi*PREC +: PREC] = y;
      assign act_clip[gi]              = clp;
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_shift_d = s1_shift_q;
    s1_cmax_d  = s1_cmax_q;
    // When S1 can accept, its occupancy follows in_valid directly: it either
    // refills or drains (its old vector having moved to S2).
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_data_d  = in_data;
      s1_mode_d  = in_mode;
      s1_shift_d = leak_shift;
      s1_cmax_d  = clip_max;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_clip_d  = s2_clip_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = act_data;
        s2_clip_d = act_clip;
      end
    end
  end

  always_comb begin
    clip_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      clip_pop = clip_pop + PCW'(s2_clip_q[i]);
    end
    cnt_sum = SUMW'(cnt_q) + SUMW'(clip_pop);
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire) begin
      cnt_d = (cnt_sum > SUMW'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNTW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_shift_q <= '0;
      s1_cmax_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_clip_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_shift_q <= s1_shift_d;
      s1_cmax_q  <= s1_cmax_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_clip_q  <= s2_clip_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_clip  = s2_clip_q;
  assign clip_cnt  = cnt_q;

endmodule
